// File: rtl/soc_ledr_pwm_if.sv
// soc_ledr_pwm_if
// Avalon-MM slave bus used to program the LED driver.
//   avs_address   : word address (ADDR_W bits)
//   avs_read      : read strobe; data is returned one cycle later
//   avs_write     : write strobe
//   avs_writedata : 32-bit write data
//   avs_readdata  : 32-bit read data, held until the next read
// ADDR_W must match the ADDR_W of the soc_ledr_pwm instance it connects to.
interface soc_ledr_pwm_if #(
  parameter int ADDR_W = 5
) ();

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );

endinterface

// File: rtl/soc_ledr_pwm.sv
// soc_ledr_pwm
// Multi-channel LED driver behind an Avalon-MM slave. Each channel can be
// off, on, PWM-dimmed or blinking. All channels share one programmable
// prescaler and one PWM counter.
//   ref_clk    : system clock, rising edge
//   fpga_reset : asynchronous active-high reset
//   avs        : Avalon-MM slave bus (soc_ledr_pwm_if.slave)
//   ledr       : registered LED drive, 1 = lit
// Register map (word addresses):
//   0      CTRL  bit0 EN
//   1      PRESC bits[PRESC_W-1:0] prescaler reload
//   2+i    CHi   bits[PWM_W-1:0] DUTY, bits[17:16] MODE, bits[31:24] HALF
module soc_ledr_pwm #(
  parameter int NUM_CH  = 8,
  parameter int ADDR_W  = 5,
  parameter int PWM_W   = 8,
  parameter int PRESC_W = 16
) (
  input  logic              ref_clk,
  input  logic              fpga_reset,
  soc_ledr_pwm_if.slave     avs,
  output logic [NUM_CH-1:0] ledr
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_PWM   = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] prescCnt_q, prescCnt_d;
  logic [PWM_W-1:0]   pcnt_q, pcnt_d;
  logic [PWM_W-1:0]   dutyShadow_q [NUM_CH];
  logic [PWM_W-1:0]   dutyShadow_d [NUM_CH];
  logic [PWM_W-1:0]   dutyActive_q [NUM_CH];
  logic [PWM_W-1:0]   dutyActive_d [NUM_CH];
  logic [1:0]         mode_q [NUM_CH];
  logic [1:0]         mode_d [NUM_CH];
  logic [7:0]         half_q [NUM_CH];
  logic [7:0]         half_d [NUM_CH];
  logic [7:0]         blinkCnt_q [NUM_CH];
  logic [7:0]         blinkCnt_d [NUM_CH];
  logic [NUM_CH-1:0]  phase_q, phase_d;
  logic [NUM_CH-1:0]  ledr_q, ledr_d;
  logic [31:0]        readData_q, readData_d;

  logic               wrCtrl, wrPresc;
  logic [NUM_CH-1:0]  wrCh;
  logic [NUM_CH-1:0]  blinkEnd;
  logic [31:0]        rdMux;
  logic               tick, frame;
  logic               unusedWriteBits;

  // Only some write-data bits land in registers; reducing the whole word
  // keeps the bus fully consumed without adding logic.
  assign unusedWriteBits = ^avs.avs_writedata;

  // Address decode for the write strobes.
  always_comb begin
    wrCtrl  = avs.avs_write && (avs.avs_address == ADDR_W'(0));
    wrPresc = avs.avs_write && (avs.avs_address == ADDR_W'(1));
    wrCh    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrCh[i] = avs.avs_write && (avs.avs_address == ADDR_W'(i + 2));
    end
  end

  // Read mux built from the current register contents, so a read that
  // coincides with a write to the same address returns the old value.
  always_comb begin
    rdMux = '0;
    if (avs.avs_address == ADDR_W'(0)) begin
      rdMux[0] = en_q;
    end else if (avs.avs_address == ADDR_W'(1)) begin
      rdMux[PRESC_W-1:0] = presc_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (avs.avs_address == ADDR_W'(i + 2)) begin
        rdMux[PWM_W-1:0] = dutyShadow_q[i];
        rdMux[17:16]     = mode_q[i];
        rdMux[31:24]     = half_q[i];
      end
    end
  end

  // Shared timebase: the prescaler counts down and reloads on every tick;
  // frame marks the tick on which the PWM counter wraps. While disabled
  // everything sits at zero, so the first enabled cycle ticks at once.
  always_comb begin
    tick       = en_q && (prescCnt_q == '0);
    frame      = tick && (&pcnt_q);
    en_d       = wrCtrl ? avs.avs_writedata[0] : en_q;
    presc_d    = wrPresc ? avs.avs_writedata[PRESC_W-1:0] : presc_q;
    readData_d = avs.avs_read ? rdMux : readData_q;
    prescCnt_d = prescCnt_q;
    pcnt_d     = pcnt_q;
    if (!en_q) begin
      prescCnt_d = '0;
      pcnt_d     = '0;
    end else if (tick) begin
      prescCnt_d = presc_q;
      pcnt_d     = pcnt_q + PWM_W'(1);
    end else begin
      prescCnt_d = prescCnt_q - PRESC_W'(1);
    end
  end

  // A blink half-period ends after max(HALF,1) frames.
  always_comb begin
    blinkEnd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (half_q[i] == 8'd0) begin
        blinkEnd[i] = (blinkCnt_q[i] == 8'd0);
      end else begin
        blinkEnd[i] = (blinkCnt_q[i] == half_q[i] - 8'd1);
      end
    end
  end

  // Per-channel registers. DUTY goes to a shadow copy and is promoted to
  // the active copy only on frame, so a frame is never cut mid-way.
  // A channel write restarts its blink dark and takes priority over frame.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      dutyShadow_d[i] = wrCh[i] ? avs.avs_writedata[PWM_W-1:0] : dutyShadow_q[i];
      mode_d[i]       = wrCh[i] ? avs.avs_writedata[17:16] : mode_q[i];
      half_d[i]       = wrCh[i] ? avs.avs_writedata[31:24] : half_q[i];
      dutyActive_d[i] = frame ? dutyShadow_q[i] : dutyActive_q[i];
      blinkCnt_d[i]   = blinkCnt_q[i];
      phase_d[i]      = phase_q[i];
      if (!en_q || wrCh[i]) begin
        blinkCnt_d[i] = 8'd0;
        phase_d[i]    = 1'b0;
      end else if (frame) begin
        if (blinkEnd[i]) begin
          blinkCnt_d[i] = 8'd0;
          phase_d[i]    = ~phase_q[i];
        end else begin
          blinkCnt_d[i] = blinkCnt_q[i] + 8'd1;
        end
      end
      ledr_d[i] = 1'b0;
      if (en_q) begin
        case (mode_q[i])
          MODE_ON:    ledr_d[i] = 1'b1;
          MODE_PWM:   ledr_d[i] = (pcnt_q < dutyActive_q[i]);
          MODE_BLINK: ledr_d[i] = phase_q[i];
          MODE_OFF:   ledr_d[i] = 1'b0;
          default:    ledr_d[i] = 1'b0;
        endcase
      end
    end
  end

  // State register for everything above.
  always_ff @(posedge ref_clk or posedge fpga_reset) begin
    if (fpga_reset) begin
      en_q         <= 1'b0;
      presc_q      <= '0;
      prescCnt_q   <= '0;
      pcnt_q       <= '0;
      dutyShadow_q <= '{default: '0};
      dutyActive_q <= '{default: '0};
      mode_q       <= '{default: '0};
      half_q       <= '{default: '0};
      blinkCnt_q   <= '{default: '0};
      phase_q      <= '0;
      ledr_q       <= '0;
      readData_q   <= '0;
    end else begin
      en_q         <= en_d;
      presc_q      <= presc_d;
      prescCnt_q   <= prescCnt_d;
      pcnt_q       <= pcnt_d;
      dutyShadow_q <= dutyShadow_d;
      dutyActive_q <= dutyActive_d;
      mode_q       <= mode_d;
      half_q       <= half_d;
      blinkCnt_q   <= blinkCnt_d;
      phase_q      <= phase_d;
      ledr_q       <= ledr_d;
      readData_q   <= readData_d;
    end
  end

  assign ledr             = ledr_q;
  assign avs.avs_readdata = readData_q;

endmodule

// File: tb/tb_soc_ledr_pwm.sv
// tb_soc_ledr_pwm
// Self-checking bench for soc_ledr_pwm. A reference model derives the PWM
// counter and blink phase arithmetically from the number of enabled cycles
// and frames elapsed, and predicts ledr and readdata every cycle.
module tb_soc_ledr_pwm;

  localparam int NUM_CH    = 8;
  localparam int ADDR_W    = 5;
  localparam int PWM_W     = 8;
  localparam int PRESC_W   = 16;
  localparam int PWM_STEPS = 1 << PWM_W;

  logic              ref_clk    = 1'b0;
  logic              fpga_reset = 1'b0;
  logic [NUM_CH-1:0] ledr;

  int compareCount  = 0;
  int mismatchCount = 0;
  bit checkOn       = 1'b0;

  soc_ledr_pwm_if #(.ADDR_W(ADDR_W)) bus ();

  soc_ledr_pwm #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .PWM_W  (PWM_W),
    .PRESC_W(PRESC_W)
  ) dut (
    .ref_clk   (ref_clk),
    .fpga_reset(fpga_reset),
    .avs       (bus),
    .ledr      (ledr)
  );

  always #5 ref_clk = ~ref_clk;

  // Reference model state
  bit                mEn = 1'b0;
  int                mP = 0;
  int                mT = 0;
  int                mFrames = 0;
  int                mShadow [NUM_CH];
  int                mActive [NUM_CH];
  int                mMode   [NUM_CH];
  int                mHalf   [NUM_CH];
  int                mBase   [NUM_CH];
  logic [NUM_CH-1:0] expLedr = '0;
  logic [31:0]       expRd   = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] regValue(input int addr);
    logic [31:0] v;
    v = '0;
    if (addr == 0) begin
      v = {31'd0, mEn};
    end else if (addr == 1) begin
      v = 32'(mP);
    end else if (addr >= 2 && addr < NUM_CH + 2) begin
      v = 32'((mHalf[addr-2] << 24) | (mMode[addr-2] << 16) | mShadow[addr-2]);
    end
    return v;
  endfunction

  task automatic clearModel();
    mEn = 1'b0; mP = 0; mT = 0; mFrames = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      mShadow[i] = 0; mActive[i] = 0; mMode[i] = 0; mHalf[i] = 0; mBase[i] = 0;
    end
    expLedr = '0;
    expRd   = '0;
  endtask

  // Model step: outputs come from the state seen before the edge, then the
  // timebase advances, then any bus write is applied.
  always @(posedge ref_clk or posedge fpga_reset) begin : refModel
    int                pcnt;
    bit                tick;
    bit                frame;
    int                hEff;
    int                addr;
    logic [31:0]       wd;
    logic [NUM_CH-1:0] nextLedr;
    if (fpga_reset) begin
      clearModel();
    end else begin
      nextLedr = '0;
      pcnt     = 0;
      tick     = 1'b0;
      frame    = 1'b0;
      if (mEn) begin
        pcnt  = ((mT + mP) / (mP + 1)) % PWM_STEPS;
        tick  = (mT % (mP + 1)) == 0;
        frame = tick && (pcnt == PWM_STEPS - 1);
        for (int i = 0; i < NUM_CH; i++) begin
          hEff = (mHalf[i] == 0) ? 1 : mHalf[i];
          case (mMode[i])
            1:       nextLedr[i] = 1'b1;
            2:       nextLedr[i] = (pcnt < mActive[i]);
            3:       nextLedr[i] = (((mFrames - mBase[i]) / hEff) % 2) == 1;
            default: nextLedr[i] = 1'b0;
          endcase
        end
      end
      addr = int'(bus.avs_address);
      if (bus.avs_read) expRd = regValue(addr);
      if (mEn) begin
        if (frame) begin
          mFrames++;
          for (int i = 0; i < NUM_CH; i++) mActive[i] = mShadow[i];
        end
        mT++;
      end else begin
        mT = 0;
        mFrames = 0;
        for (int i = 0; i < NUM_CH; i++) mBase[i] = 0;
      end
      if (bus.avs_write) begin
        wd = bus.avs_writedata;
        if (addr == 0) begin
          mEn = wd[0];
        end else if (addr == 1) begin
          mP = int'(wd[PRESC_W-1:0]);
        end else if (addr >= 2 && addr < NUM_CH + 2) begin
          mShadow[addr-2] = int'(wd[PWM_W-1:0]);
          mMode[addr-2]   = int'(wd[17:16]);
          mHalf[addr-2]   = int'(wd[31:24]);
          mBase[addr-2]   = mFrames;
        end
      end
      expLedr = nextLedr;
    end
  end

  // Every cycle, compare both outputs away from the active edge.
  always @(negedge ref_clk) begin
    if (checkOn) begin
      checkOutput("ledr", 32'(ledr), 32'(expLedr));
      checkOutput("readdata", bus.avs_readdata, expRd);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge ref_clk);
  endtask

  task automatic busWrite(input int addr, input logic [31:0] data);
    @(negedge ref_clk);
    bus.avs_address   = ADDR_W'(addr);
    bus.avs_writedata = data;
    bus.avs_write     = 1'b1;
    @(negedge ref_clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic busRead(input int addr);
    @(negedge ref_clk);
    bus.avs_address = ADDR_W'(addr);
    bus.avs_read    = 1'b1;
    @(negedge ref_clk);
    bus.avs_read    = 1'b0;
  endtask

  task automatic busReadWrite(input int addr, input logic [31:0] data);
    @(negedge ref_clk);
    bus.avs_address   = ADDR_W'(addr);
    bus.avs_writedata = data;
    bus.avs_read      = 1'b1;
    bus.avs_write     = 1'b1;
    @(negedge ref_clk);
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
  endtask

  function automatic logic [31:0] randomChWord();
    logic [7:0] duty;
    case ($urandom_range(0, 3))
      0:       duty = 8'd0;
      1:       duty = 8'd255;
      default: duty = 8'($urandom);
    endcase
    return {8'($urandom_range(0, 3)), 6'($urandom), 2'($urandom), 8'($urandom), duty};
  endfunction

  // Random rounds: reconfigure while disabled (PRESC only changes then),
  // enable, and mix channel writes, reads and read+write collisions.
  task automatic applyStimulus(input int rounds);
    int ch;
    for (int r = 0; r < rounds; r++) begin
      busWrite(0, {31'($urandom), 1'b0});
      busWrite(1, {16'($urandom), 16'($urandom_range(0, 2))});
      for (int i = 0; i < NUM_CH; i++) busWrite(i + 2, randomChWord());
      busWrite(0, {31'($urandom), 1'b1});
      for (int k = 0; k < 8; k++) begin
        idle($urandom_range(20, 300));
        ch = $urandom_range(0, NUM_CH - 1);
        case ($urandom_range(0, 2))
          0:       busWrite(ch + 2, randomChWord());
          1:       busRead($urandom_range(0, (1 << ADDR_W) - 1));
          default: busReadWrite(ch + 2, randomChWord());
        endcase
      end
    end
  endtask

  initial begin
    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    #1 fpga_reset = 1'b1;
    #1 checkOn = 1'b1;
    idle(3);
    fpga_reset = 1'b0;

    // Every address reads 0 after reset.
    for (int a = 0; a < (1 << ADDR_W); a++) busRead(a);

    // Static on/off, then global disable.
    busWrite(2, 32'h0001_0000);
    busWrite(3, 32'h0000_0000);
    busWrite(0, 32'h0000_0001);
    idle(20);
    busWrite(0, 32'h0000_0000);
    idle(5);

    // PWM on CH2 with a mid-frame duty change.
    busWrite(1, 32'd0);
    busWrite(4, 32'h0002_0040);
    busWrite(0, 32'd1);
    idle(300);
    busWrite(4, 32'h0002_00C0);
    idle(700);

    // Blink on CH3 at PRESC=3: HALF=2, then HALF=0.
    busWrite(0, 32'd0);
    busWrite(1, 32'd3);
    busWrite(5, 32'h0203_0000);
    busWrite(0, 32'd1);
    idle(7000);
    busWrite(5, 32'h0003_0000);
    idle(3000);

    // Read/write collision on CH4, then an unmapped address.
    busWrite(6, 32'h0000_0011);
    busReadWrite(6, 32'h0000_0022);
    busRead(6);
    busRead(NUM_CH + 2);

    // Asynchronous reset in the middle of a PWM frame.
    busWrite(0, 32'd0);
    busWrite(1, 32'd0);
    busWrite(4, 32'h0002_0080);
    busWrite(0, 32'd1);
    busRead(4);
    idle(100);
    @(posedge ref_clk);
    #2 fpga_reset = 1'b1;
    #1;
    checkOutput("asyncLedr", 32'(ledr), 32'd0);
    checkOutput("asyncReadData", bus.avs_readdata, 32'd0);
    @(posedge ref_clk);
    @(negedge ref_clk);
    fpga_reset = 1'b0;
    for (int a = 0; a < NUM_CH + 2; a++) busRead(a);
    busWrite(4, 32'h0002_0020);
    busWrite(0, 32'd1);
    idle(600);

    applyStimulus(10);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
